// File: rtl/button_reader.sv
// Per-bit synchronizer and debouncer with rise/fall pulses and a sticky,
// acknowledgeable record of accepted rising edges.
module button_reader #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_rise,
    output logic [WIDTH-1:0] btn_fall,
    output logic [WIDTH-1:0] evt_bits,
    output logic             evt_pending,
    input  logic             evt_ack
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]            s1_q;
    logic [WIDTH-1:0]            s2_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            level_q;
    logic [WIDTH-1:0]            level_d;
    logic [WIDTH-1:0]            rise_q;
    logic [WIDTH-1:0]            rise_d;
    logic [WIDTH-1:0]            fall_q;
    logic [WIDTH-1:0]            fall_d;
    logic [WIDTH-1:0]            evt_q;
    logic [WIDTH-1:0]            evt_d;
    logic                        pending_q;

    // Counter only runs while the synchronized input disagrees with the accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                level_d[i] = s2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
        // A rise at the acknowledge edge survives the clear.
        evt_d  = (evt_q & ~{WIDTH{evt_ack}}) | rise_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            evt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            s1_q      <= btn_in;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            evt_q     <= evt_d;
            pending_q <= |evt_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_rise    = rise_q;
    assign btn_fall    = fall_q;
    assign evt_bits    = evt_q;
    assign evt_pending = pending_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with WIDTH=8, STABLE_CYCLES=4.
module tb_button_reader;

    logic       clk;
    logic       reset;
    logic [7:0] btn_in;
    logic [7:0] btn_level;
    logic [7:0] btn_rise;
    logic [7:0] btn_fall;
    logic [7:0] evt_bits;
    logic       evt_pending;
    logic       evt_ack;

    int checks = 0;
    int errors = 0;

    button_reader #(
        .WIDTH         (8),
        .STABLE_CYCLES (4),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_rise    (btn_rise),
        .btn_fall    (btn_fall),
        .evt_bits    (evt_bits),
        .evt_pending (evt_pending),
        .evt_ack     (evt_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; inputs driven and outputs sampled 1 time unit after an edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        btn_in  = 8'h00;
        evt_ack = 1'b0;
        step(2);
        checks++;
        if ({btn_level, btn_rise, btn_fall, evt_bits, evt_pending} !== 41'd0) begin
            errors++;
            $display("FAIL reset_state got lvl=%h rise=%h fall=%h evt=%h pend=%b exp all zero",
                     btn_level, btn_rise, btn_fall, evt_bits, evt_pending);
        end
        reset = 1'b0;
    endtask

    task automatic test_glitch;
        logic [7:0] pattern [0:11];
        pattern = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 12; i++) begin
            btn_in = pattern[i];
            step(1);
            checks++;
            if ({btn_level, btn_rise, evt_bits} !== 24'd0) begin
                errors++;
                $display("FAIL glitch_%0d got lvl=%h rise=%h evt=%h exp 00 00 00",
                         i, btn_level, btn_rise, evt_bits);
            end
        end
    endtask

    task automatic test_rise;
        btn_in = 8'h01;
        step(5);
        checks++;
        if (btn_level !== 8'h00 || btn_rise !== 8'h00) begin
            errors++;
            $display("FAIL rise_early got lvl=%h rise=%h exp 00 00", btn_level, btn_rise);
        end
        step(1);
        checks++;
        if (btn_level !== 8'h01 || btn_rise !== 8'h01 || btn_fall !== 8'h00) begin
            errors++;
            $display("FAIL rise_edge got lvl=%h rise=%h fall=%h exp 01 01 00",
                     btn_level, btn_rise, btn_fall);
        end
        checks++;
        if (evt_bits !== 8'h01 || evt_pending !== 1'b1) begin
            errors++;
            $display("FAIL rise_evt got evt=%h pend=%b exp 01 1", evt_bits, evt_pending);
        end
        step(1);
        checks++;
        if (btn_rise !== 8'h00 || btn_level !== 8'h01) begin
            errors++;
            $display("FAIL rise_pulse_end got rise=%h lvl=%h exp 00 01", btn_rise, btn_level);
        end
    endtask

    task automatic test_fall;
        btn_in = 8'h00;
        step(5);
        checks++;
        if (btn_fall !== 8'h00 || btn_level !== 8'h01) begin
            errors++;
            $display("FAIL fall_early got fall=%h lvl=%h exp 00 01", btn_fall, btn_level);
        end
        step(1);
        checks++;
        if (btn_fall !== 8'h01 || btn_rise !== 8'h00 || btn_level !== 8'h00) begin
            errors++;
            $display("FAIL fall_edge got fall=%h rise=%h lvl=%h exp 01 00 00",
                     btn_fall, btn_rise, btn_level);
        end
        checks++;
        if (evt_bits !== 8'h01 || evt_pending !== 1'b1) begin
            errors++;
            $display("FAIL fall_evt got evt=%h pend=%b exp 01 1", evt_bits, evt_pending);
        end
        step(1);
        checks++;
        if (btn_fall !== 8'h00) begin
            errors++;
            $display("FAIL fall_pulse_end got fall=%h exp 00", btn_fall);
        end
    endtask

    task automatic test_ack_set_wins;
        btn_in = 8'h08;
        step(5);
        evt_ack = 1'b1;
        step(1);
        evt_ack = 1'b0;
        checks++;
        if (evt_bits !== 8'h08 || evt_pending !== 1'b1 || btn_rise !== 8'h08) begin
            errors++;
            $display("FAIL ack_set_wins got evt=%h pend=%b rise=%h exp 08 1 08",
                     evt_bits, evt_pending, btn_rise);
        end
    endtask

    task automatic test_reset_mid;
        evt_ack = 1'b1;
        step(1);
        evt_ack = 1'b0;
        checks++;
        if (evt_bits !== 8'h00 || evt_pending !== 1'b0) begin
            errors++;
            $display("FAIL ack_clear got evt=%h pend=%b exp 00 0", evt_bits, evt_pending);
        end
        btn_in = 8'h05;
        step(6);
        checks++;
        if (btn_level !== 8'h05 || btn_rise !== 8'h05 || btn_fall !== 8'h08 ||
            evt_bits !== 8'h05) begin
            errors++;
            $display("FAIL multi_bit got lvl=%h rise=%h fall=%h evt=%h exp 05 05 08 05",
                     btn_level, btn_rise, btn_fall, evt_bits);
        end
        btn_in = 8'h01;
        step(7);
        checks++;
        if (btn_level !== 8'h01 || evt_bits !== 8'h05) begin
            errors++;
            $display("FAIL bit2_fall got lvl=%h evt=%h exp 01 05", btn_level, evt_bits);
        end
        // Bit 2 back high; two edges into its count when reset hits.
        btn_in = 8'h05;
        step(4);
        reset = 1'b1;
        step(1);
        checks++;
        if ({btn_level, btn_rise, btn_fall, evt_bits, evt_pending} !== 41'd0) begin
            errors++;
            $display("FAIL reset_mid got lvl=%h rise=%h fall=%h evt=%h pend=%b exp all zero",
                     btn_level, btn_rise, btn_fall, evt_bits, evt_pending);
        end
        reset = 1'b0;
        step(5);
        checks++;
        if (btn_rise !== 8'h00 || btn_level !== 8'h00) begin
            errors++;
            $display("FAIL reset_relatch_early got rise=%h lvl=%h exp 00 00", btn_rise, btn_level);
        end
        step(1);
        checks++;
        if (btn_rise !== 8'h05 || btn_level !== 8'h05 || evt_bits !== 8'h05 ||
            evt_pending !== 1'b1) begin
            errors++;
            $display("FAIL reset_relatch got rise=%h lvl=%h evt=%h pend=%b exp 05 05 05 1",
                     btn_rise, btn_level, evt_bits, evt_pending);
        end
    endtask

    task automatic test_all_bits;
        btn_in  = 8'h00;
        evt_ack = 1'b1;
        step(1);
        evt_ack = 1'b0;
        step(7);
        checks++;
        if (btn_level !== 8'h00 || evt_bits !== 8'h00 || evt_pending !== 1'b0) begin
            errors++;
            $display("FAIL all_clear got lvl=%h evt=%h pend=%b exp 00 00 0",
                     btn_level, evt_bits, evt_pending);
        end
        evt_ack = 1'b1;
        step(1);
        evt_ack = 1'b0;
        checks++;
        if (evt_bits !== 8'h00 || evt_pending !== 1'b0 || btn_level !== 8'h00) begin
            errors++;
            $display("FAIL idle_ack got evt=%h pend=%b lvl=%h exp 00 0 00",
                     evt_bits, evt_pending, btn_level);
        end
        btn_in = 8'hFF;
        step(5);
        checks++;
        if (btn_rise !== 8'h00) begin
            errors++;
            $display("FAIL all_early got rise=%h exp 00", btn_rise);
        end
        step(1);
        checks++;
        if (btn_rise !== 8'hFF || btn_fall !== 8'h00 || evt_bits !== 8'hFF ||
            evt_pending !== 1'b1) begin
            errors++;
            $display("FAIL all_rise got rise=%h fall=%h evt=%h pend=%b exp FF 00 FF 1",
                     btn_rise, btn_fall, evt_bits, evt_pending);
        end
        step(1);
        checks++;
        if (btn_rise !== 8'h00 || evt_bits !== 8'hFF) begin
            errors++;
            $display("FAIL all_pulse_end got rise=%h evt=%h exp 00 FF", btn_rise, evt_bits);
        end
        evt_ack = 1'b1;
        step(1);
        evt_ack = 1'b0;
        checks++;
        if (evt_bits !== 8'h00 || evt_pending !== 1'b0) begin
            errors++;
            $display("FAIL all_ack got evt=%h pend=%b exp 00 0", evt_bits, evt_pending);
        end
        step(1);
        checks++;
        if (evt_bits !== 8'h00 || btn_level !== 8'hFF) begin
            errors++;
            $display("FAIL all_after got evt=%h lvl=%h exp 00 FF", evt_bits, btn_level);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_rise();
        test_fall();
        test_ack_set_wins();
        test_reset_mid();
        test_all_bits();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
